// File: rtl/if_id_pkg.sv
// Shared IF/ID definitions: occupancy state encoding and default field geometry,
// also used by the ID decoder so both sides agree on where fields sit.
package if_id_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

    localparam int DEF_INSTR_W = 32;
    localparam int DEF_PC_W    = 4;
    localparam int DEF_REG_W   = 5;
    localparam int DEF_RS_LSB  = 25;
    localparam int DEF_RT_LSB  = 20;
    localparam int DEF_RD_LSB  = 15;
    localparam int DEF_IMM_W   = 16;
    localparam int DEF_IMM_LSB = 4;
    localparam int DEF_DROP_W  = 8;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: data register plus valid flop. Clear beats load and
// zeroes the data so an invalidated entry presents an all-zero bubble.
module pipe_entry_reg #(
    parameter int DATA_W = 36
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic              valid,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF->ID elastic stage with a main entry driving ID and a skid entry that absorbs
// the one instruction in flight when ID stalls; in_ready never depends on out_ready.
module if_id_skid_stage
    import if_id_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int PC_W    = DEF_PC_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int RS_LSB  = DEF_RS_LSB,
    parameter int RT_LSB  = DEF_RT_LSB,
    parameter int RD_LSB  = DEF_RD_LSB,
    parameter int IMM_W   = DEF_IMM_W,
    parameter int IMM_LSB = DEF_IMM_LSB,
    parameter int DROP_W  = DEF_DROP_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [REG_W-1:0]   out_rs,
    output logic [REG_W-1:0]   out_rt,
    output logic [REG_W-1:0]   out_rd,
    output logic [IMM_W-1:0]   out_imm,
    output logic [1:0]         occupancy,
    output logic [DROP_W-1:0]  drop_count
);

    localparam int ENTRY_W = INSTR_W + PC_W;

    if ((RS_LSB + REG_W > INSTR_W) || (RT_LSB + REG_W > INSTR_W) ||
        (RD_LSB + REG_W > INSTR_W) || (IMM_LSB + IMM_W > INSTR_W)) begin : g_bad_slice
        $error("if_id_skid_stage: decoded field slice exceeds INSTR_W");
    end

    occ_state_e         state;
    logic               push, pop;
    logic               main_load, main_clear, skid_load, skid_clear;
    logic [ENTRY_W-1:0] in_entry, main_d, main_q, skid_q;
    logic               main_valid, skid_valid;
    logic [DROP_W:0]    drop_sum;

    assign in_entry  = {in_instr, in_pc};
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    // The skid valid bit is itself a flop, so ready is registered by construction.
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign occupancy = state;

    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = in_entry;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                EMPTY: main_load = push;
                HALF: begin
                    if (push && pop) main_load = 1'b1;
                    else if (push)   skid_load = 1'b1;
                    else if (pop)    main_clear = 1'b1;
                end
                FULL: begin
                    if (pop) begin
                        main_load  = 1'b1;
                        main_d     = skid_q;
                        skid_clear = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    pipe_entry_reg #(.DATA_W(ENTRY_W)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    pipe_entry_reg #(.DATA_W(ENTRY_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_entry),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign drop_sum = {1'b0, drop_count} + {{(DROP_W-1){1'b0}}, occupancy};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            drop_count <= '0;
        end else if (flush) begin
            state      <= EMPTY;
            drop_count <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end else begin
            unique case (state)
                EMPTY: if (push) state <= HALF;
                HALF: begin
                    if (push && !pop)      state <= FULL;
                    else if (pop && !push) state <= EMPTY;
                end
                FULL: if (pop) state <= HALF;
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_instr = main_q[ENTRY_W-1:PC_W];
    assign out_pc    = main_q[PC_W-1:0];
    assign out_rs    = out_instr[RS_LSB +: REG_W];
    assign out_rt    = out_instr[RT_LSB +: REG_W];
    assign out_rd    = out_instr[RD_LSB +: REG_W];
    assign out_imm   = out_instr[IMM_LSB +: IMM_W];

endmodule
